// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: front-end controller for the ALU unit bank.
// It accepts one command at a time and strobes exactly one unit (arith, logic, cmp or shift).
// It then waits, with a timeout, for that unit's completion flag.
// The unit's result is widened to 2W and held on a valid/ready result port until it is taken.
module alu_op_sequencer #(
  parameter int In_Data_Width  = 8,
  parameter int TIMEOUT_CYCLES = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [3:0]                   cmd_opcode,
  input  logic [In_Data_Width-1:0]     cmd_a,
  input  logic [In_Data_Width-1:0]     cmd_b,
  output logic [In_Data_Width-1:0]     unit_a,
  output logic [In_Data_Width-1:0]     unit_b,
  output logic [1:0]                   alu_fun,
  output logic                         arith_enable,
  output logic                         logic_enable,
  output logic                         cmp_enable,
  output logic                         shift_enable,
  input  logic [2*In_Data_Width-1:0]   arith_out,
  input  logic                         arith_flag,
  input  logic [In_Data_Width-1:0]     logic_out,
  input  logic                         logic_flag,
  input  logic [2:0]                   cmp_out,
  input  logic                         cmp_flag,
  input  logic [In_Data_Width-1:0]     shift_out,
  input  logic                         shift_flag,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [2*In_Data_Width-1:0]   res_data,
  output logic                         res_err,
  output logic [CNT_WIDTH-1:0]         op_count
);

  localparam int W  = In_Data_Width;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] U_ARITH = 2'b00;
  localparam logic [1:0] U_LOGIC = 2'b01;
  localparam logic [1:0] U_CMP   = 2'b10;
  localparam logic [1:0] U_SHIFT = 2'b11;

  logic [1:0]    state;
  logic [1:0]    unit_sel;
  logic [TW-1:0] tcnt;
  logic          sel_flag;
  logic [2*W-1:0] sel_data;

  assign cmd_ready = (state == S_IDLE);

  // One-hot unit strobe, only during the single ISSUE cycle
  always_comb begin
    arith_enable = 1'b0;
    logic_enable = 1'b0;
    cmp_enable   = 1'b0;
    shift_enable = 1'b0;
    if (state == S_ISSUE) begin
      case (unit_sel)
        U_ARITH: arith_enable = 1'b1;
        U_LOGIC: logic_enable = 1'b1;
        U_CMP:   cmp_enable   = 1'b1;
        default: shift_enable = 1'b1;
      endcase
    end
  end

  // Select the active unit's flag and widen its result; other units' flags are never looked at
  always_comb begin
    sel_flag = 1'b0;
    sel_data = '0;
    case (unit_sel)
      U_ARITH: begin sel_flag = arith_flag; sel_data = arith_out; end
      U_LOGIC: begin sel_flag = logic_flag; sel_data = {{W{1'b0}}, logic_out}; end
      U_CMP:   begin sel_flag = cmp_flag;   sel_data = {{(2*W-3){1'b0}}, cmp_out}; end
      U_SHIFT: begin sel_flag = shift_flag; sel_data = {{W{1'b0}}, shift_out}; end
      default: ;
    endcase
  end

  // Sequencer FSM, operand/result registers, timeout and completion counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      unit_sel  <= U_ARITH;
      alu_fun   <= 2'b00;
      unit_a    <= '0;
      unit_b    <= '0;
      tcnt      <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
      op_count  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            unit_sel <= cmd_opcode[3:2];
            alu_fun  <= cmd_opcode[1:0];
            unit_a   <= cmd_a;
            unit_b   <= cmd_b;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (sel_flag) begin
            res_data  <= sel_data;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            tcnt      <= '0;
            state     <= S_DONE;
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            res_data  <= '0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            tcnt      <= '0;
            state     <= S_DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_count  <= op_count + 1'b1;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
